game_sequencer: RTL and testbench
=================================

# game_sequencer

Central game controller for the flappy VGA design: sequences IDLE → PLAY → LOSE, turns raw buttons into clean single-cycle commands, and issues frame-locked step strobes to the pipe, physics and collision units in place of divided clocks. It owns the BCD score and high score and drives the lose-flash bit to the colour mux. It sits between the board buttons and hvsync_generator on one side, and the pipe RAM, flight physics and obstacle checker on the other.

## Interface
- DEBOUNCE_CYCLES, 20'd500000: cycles a button must be stable before it is accepted.
- PIPE_DIV, 4'd1: frames per pipe_step.
- PHYS_DIV, 4'd2: frames per phys_step.
- FLASH_FRAMES, 6'd12: frames per flash toggle in LOSE.
- Clk  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- BtnC  in  1  raw jump button.
- BtnD  in  1  raw start/ack button.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- collide  in  1  level from obstacle checker.
- pipe_passed  in  1  one-cycle pulse when a pipe leaves scope.
- clear  out  1  one-cycle datapath clear.
- run  out  1  high in PLAY.
- pipe_step  out  1  one-cycle pipe advance strobe.
- phys_step  out  1  one-cycle physics update strobe.
- jump  out  1  one-cycle debounced BtnC press, PLAY only.
- Score  out  8  two BCD digits, {tens, ones}.
- HiScore  out  8  two BCD digits.
- flash  out  1  lose-flash colour bit.
- state  out  2  00 IDLE, 01 PLAY, 10 LOSE.

## Operation
- Each button goes through btn_pulse: the 2-flop synchronised input must be stable for DEBOUNCE_CYCLES, then a 1-cycle pulse is emitted on the accepted 0→1 edge. Release produces no pulse.
- States:
  - IDLE: run=0; no strobes.
  - IDLE + D-pulse → PLAY. clear=1 in the transition cycle; Score←0.
  - PLAY: run=1.
  - PLAY + frame_start with collide=1 → LOSE. HiScore←max(HiScore, Score), using Score after any same-cycle increment.
  - LOSE: run=0; flash toggles every FLASH_FRAMES frame_start pulses.
  - LOSE + D-pulse → IDLE. flash←0; Score is held.
- Step strobes apply only in PLAY on a frame_start with collide=0.
  - pipe_cnt and phys_cnt each count frame_starts.
  - When a counter reaches its DIV-1, it wraps to 0 and its strobe pulses.
  - Both counters clear with clear.
- On the collision frame, neither strobe fires.
- jump = C-pulse AND state==PLAY. Presses in other states are discarded, not queued.
- Score increments on pipe_passed in PLAY.
  - The ones digit wraps 9→0 and carries into tens.
  - Score saturates at 99.
  - pipe_passed in the same cycle as the collision transition is counted.
- A D-pulse coinciding with frame_start/collide in PLAY is ignored; collision handling takes priority.

## Timing
- Reset values: state=IDLE, run=0, clear=0, strobes=0, jump=0, Score=0, HiScore=0, flash=0, all counters=0.
- Reset mid-game returns to IDLE on the next edge and clears HiScore.
- All outputs are registered.
- Latencies:
  - frame_start at cycle t → pipe_step/phys_step at t+1.
  - D-pulse at t → clear and state change at t+1; run high from t+1.
  - pipe_passed at t → Score updated at t+1.
  - Button edge → pulse after 2 + DEBOUNCE_CYCLES cycles.
- Strobes are never asserted for more than one cycle; two frame_starts are never closer than one line.

## Structure
- Shared package game_pkg holds:
  - state encodings (ST_IDLE, ST_PLAY, ST_LOSE);
  - BCD saturating-increment function;
  - BCD compare function, shared with the score display.
- Sub-module btn_pulse (sync, debounce, edge detect), parameterised by DEBOUNCE_CYCLES. Two instances: one for BtnC, one for BtnD.
- The FSM, frame counters, score and flash logic live in game_sequencer.

## Test plan
- Reset, then BtnD held for DEBOUNCE_CYCLES+2 (bench uses DEBOUNCE_CYCLES=4) → clear is one pulse; state=01; run=1; Score=00.
- PLAY, PIPE_DIV=1, PHYS_DIV=2, 6 frame_starts → 6 pipe_steps; 3 phys_steps (on frames 2, 4, 6), each one cycle after its frame_start.
- 12 pipe_passed pulses, then 100 pulses → Score=12h, then saturates at 99h.
- collide=1 on a frame_start with Score=07h and HiScore=05h → LOSE next cycle; no strobes that frame; HiScore=07h; flash toggles every 12 frames.
- Glitchy BtnC (bounces shorter than 4 cycles) in PLAY → no jump. A clean press gives exactly one jump pulse. A press in IDLE gives no jump.
- Reset asserted mid-PLAY with Score=05h → next cycle: state=00, Score=00, HiScore=00, run=0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the flappy game controller: state encodings and
// two-digit BCD helpers (also used by the score display).
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_LOSE = 2'b10
    } state_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_MAX  = 8'h99;

    // Increment a {tens, ones} BCD value, holding at 99.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_MAX) begin
            r = BCD_MAX;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // True when BCD value a is strictly greater than b.
    function automatic logic bcd_gt(input logic [7:0] a, input logic [7:0] b);
        return (a[7:4] > b[7:4]) || ((a[7:4] == b[7:4]) && (a[3:0] > b[3:0]));
    endfunction

endpackage

// File: rtl/game_sequencer_btn_pulse.sv
// Button conditioner: two-flop synchroniser, stability debounce, and a
// single-cycle pulse on each accepted press (releases are silent).
module btn_pulse #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic srst,
    input  logic btn,
    output logic pulse
);

    logic [1:0]  sync_reg;
    logic        stable_reg;
    logic [19:0] cnt_reg;
    logic        pulse_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg   <= 2'b00;
            stable_reg <= 1'b0;
            cnt_reg    <= 20'd0;
            pulse_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            pulse_reg <= 1'b0;
            if (sync_reg[1] == stable_reg) begin
                cnt_reg <= 20'd0;
            end else if (cnt_reg == DEBOUNCE_CYCLES - 20'd1) begin
                // New level has held long enough; only a rising level pulses.
                stable_reg <= sync_reg[1];
                cnt_reg    <= 20'd0;
                pulse_reg  <= sync_reg[1];
            end else begin
                cnt_reg <= cnt_reg + 20'd1;
            end
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/game_sequencer.sv
// Game controller: IDLE/PLAY/LOSE sequencing, frame-locked step strobes,
// BCD score and high score, and the lose-flash bit.
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [3:0]  PIPE_DIV        = 4'd1,
    parameter logic [3:0]  PHYS_DIV        = 4'd2,
    parameter logic [5:0]  FLASH_FRAMES    = 6'd12
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       BtnC,
    input  logic       BtnD,
    input  logic       frame_start,
    input  logic       collide,
    input  logic       pipe_passed,
    output logic       clear,
    output logic       run,
    output logic       pipe_step,
    output logic       phys_step,
    output logic       jump,
    output logic [7:0] Score,
    output logic [7:0] HiScore,
    output logic       flash,
    output logic [1:0] state
);

    logic [1:0] btn_raw;
    logic [1:0] btn_evt;

    assign btn_raw = {BtnD, BtnC};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            btn_pulse #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_btn (
                .clk  (Clk),
                .srst (reset),
                .btn  (btn_raw[gi]),
                .pulse(btn_evt[gi])
            );
        end
    endgenerate

    logic c_pulse;
    logic d_pulse;

    assign c_pulse = btn_evt[0];
    assign d_pulse = btn_evt[1];

    state_t     state_reg;
    logic       clear_reg;
    logic       run_reg;
    logic       pipe_step_reg;
    logic       phys_step_reg;
    logic       jump_reg;
    logic [7:0] score_reg;
    logic [7:0] hiscore_reg;
    logic       flash_reg;
    logic [3:0] pipe_cnt_reg;
    logic [3:0] phys_cnt_reg;
    logic [5:0] flash_cnt_reg;

    // Score including this cycle's pipe_passed, so the collision frame counts it.
    logic [7:0] score_next;
    assign score_next = pipe_passed ? bcd_inc_sat(score_reg) : score_reg;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            clear_reg     <= 1'b0;
            run_reg       <= 1'b0;
            pipe_step_reg <= 1'b0;
            phys_step_reg <= 1'b0;
            jump_reg      <= 1'b0;
            score_reg     <= BCD_ZERO;
            hiscore_reg   <= BCD_ZERO;
            flash_reg     <= 1'b0;
            pipe_cnt_reg  <= 4'd0;
            phys_cnt_reg  <= 4'd0;
            flash_cnt_reg <= 6'd0;
        end else begin
            clear_reg     <= 1'b0;
            pipe_step_reg <= 1'b0;
            phys_step_reg <= 1'b0;
            jump_reg      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (d_pulse) begin
                        state_reg    <= ST_PLAY;
                        clear_reg    <= 1'b1;
                        run_reg      <= 1'b1;
                        score_reg    <= BCD_ZERO;
                        pipe_cnt_reg <= 4'd0;
                        phys_cnt_reg <= 4'd0;
                    end
                end
                ST_PLAY: begin
                    jump_reg  <= c_pulse;
                    score_reg <= score_next;
                    if (frame_start && collide) begin
                        state_reg     <= ST_LOSE;
                        run_reg       <= 1'b0;
                        hiscore_reg   <= bcd_gt(score_next, hiscore_reg) ? score_next : hiscore_reg;
                        flash_reg     <= 1'b0;
                        flash_cnt_reg <= 6'd0;
                    end else if (frame_start) begin
                        if (pipe_cnt_reg == PIPE_DIV - 4'd1) begin
                            pipe_cnt_reg  <= 4'd0;
                            pipe_step_reg <= 1'b1;
                        end else begin
                            pipe_cnt_reg <= pipe_cnt_reg + 4'd1;
                        end
                        if (phys_cnt_reg == PHYS_DIV - 4'd1) begin
                            phys_cnt_reg  <= 4'd0;
                            phys_step_reg <= 1'b1;
                        end else begin
                            phys_cnt_reg <= phys_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_LOSE: begin
                    if (d_pulse) begin
                        state_reg     <= ST_IDLE;
                        flash_reg     <= 1'b0;
                        flash_cnt_reg <= 6'd0;
                    end else if (frame_start) begin
                        if (flash_cnt_reg == FLASH_FRAMES - 6'd1) begin
                            flash_cnt_reg <= 6'd0;
                            flash_reg     <= ~flash_reg;
                        end else begin
                            flash_cnt_reg <= flash_cnt_reg + 6'd1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    run_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign clear     = clear_reg;
    assign run       = run_reg;
    assign pipe_step = pipe_step_reg;
    assign phys_step = phys_step_reg;
    assign jump      = jump_reg;
    assign Score     = score_reg;
    assign HiScore   = hiscore_reg;
    assign flash     = flash_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: directed stimulus pushes expected
// output events; a negedge monitor pops and compares each observed event.
module tb_game_sequencer;

    localparam int DEB = 4;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       BtnC = 1'b0;
    logic       BtnD = 1'b0;
    logic       frame_start = 1'b0;
    logic       collide = 1'b0;
    logic       pipe_passed = 1'b0;
    logic       clear, run, pipe_step, phys_step, jump, flash;
    logic [7:0] Score, HiScore;
    logic [1:0] state;

    game_sequencer #(
        .DEBOUNCE_CYCLES(20'd4),
        .PIPE_DIV       (4'd1),
        .PHYS_DIV       (4'd2),
        .FLASH_FRAMES   (6'd12)
    ) dut (
        .Clk        (Clk),
        .reset      (reset),
        .BtnC       (BtnC),
        .BtnD       (BtnD),
        .frame_start(frame_start),
        .collide    (collide),
        .pipe_passed(pipe_passed),
        .clear      (clear),
        .run        (run),
        .pipe_step  (pipe_step),
        .phys_step  (phys_step),
        .jump       (jump),
        .Score      (Score),
        .HiScore    (HiScore),
        .flash      (flash),
        .state      (state)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    localparam int EV_CLEAR = 0, EV_STATE = 1, EV_SCORE = 2, EV_HI = 3,
                   EV_FLASH = 4, EV_PIPE = 5, EV_PHYS = 6, EV_JUMP = 7;

    typedef struct {
        int         kind;
        logic [7:0] val;
        int         due;
    } ev_t;

    ev_t exp_q[$];
    int  compared = 0;
    int  mismatched = 0;
    int  due = 0;
    bit  mon_en = 1'b0;

    function automatic string ev_name(input int k);
        case (k)
            EV_CLEAR: return "clear";
            EV_STATE: return "state";
            EV_SCORE: return "Score";
            EV_HI:    return "HiScore";
            EV_FLASH: return "flash";
            EV_PIPE:  return "pipe_step";
            EV_PHYS:  return "phys_step";
            default:  return "jump";
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        int m;
        m = (n > 99) ? 99 : n;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic push(input int kind, input logic [7:0] val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.due  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string nm, input logic [7:0] act, input logic [7:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic check_ev(input int kind, input logic [7:0] val);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: actual %s=%h at cycle %0d, required no event",
                     ev_name(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.due != cyc) begin
                mismatched++;
                $display("FAIL event_%s: actual %s=%h at cycle %0d, required %s=%h at cycle %0d",
                         ev_name(e.kind), ev_name(kind), val, cyc, ev_name(e.kind), e.val, e.due);
            end
        end
    endtask

    logic [1:0] prev_state = 2'b00;
    logic [7:0] prev_score = 8'h00;
    logic [7:0] prev_hi = 8'h00;
    logic       prev_flash = 1'b0;

    always @(negedge Clk) begin
        if (mon_en) begin
            if (clear) check_ev(EV_CLEAR, 8'h00);
            if (state !== prev_state) begin
                check_ev(EV_STATE, {6'd0, state});
                check_val("run_vs_state", {7'd0, run}, {7'd0, state == 2'b01});
            end
            if (Score !== prev_score) check_ev(EV_SCORE, Score);
            if (HiScore !== prev_hi) check_ev(EV_HI, HiScore);
            if (flash !== prev_flash) check_ev(EV_FLASH, {7'd0, flash});
            if (pipe_step) check_ev(EV_PIPE, 8'h00);
            if (phys_step) check_ev(EV_PHYS, 8'h00);
            if (jump) check_ev(EV_JUMP, 8'h00);
            prev_state = state;
            prev_score = Score;
            prev_hi    = HiScore;
            prev_flash = flash;
        end
    end

    task automatic start_frame(input bit col, input bit pp);
        @(negedge Clk);
        frame_start = 1'b1;
        collide     = col;
        pipe_passed = pp;
        due = cyc + 1;
    endtask

    task automatic start_pass();
        @(negedge Clk);
        pipe_passed = 1'b1;
        due = cyc + 1;
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        frame_start = 1'b0;
        collide     = 1'b0;
        pipe_passed = 1'b0;
        repeat (n - 1) @(negedge Clk);
    endtask

    // Raise a button; the command lands 2 sync + DEB stable + 1 FSM cycles later.
    task automatic press(input bit on_d);
        @(negedge Clk);
        if (on_d) BtnD = 1'b1;
        else BtnC = 1'b1;
        due = cyc + DEB + 3;
    endtask

    task automatic release_after(input int hold);
        repeat (hold) @(negedge Clk);
        BtnD = 1'b0;
        BtnC = 1'b0;
        repeat (DEB + 6) @(negedge Clk);
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        check_val("reset_state", {6'd0, state}, 8'h00);
        check_val("reset_run", {7'd0, run}, 8'h00);
        check_val("reset_clear", {7'd0, clear}, 8'h00);
        check_val("reset_pipe_step", {7'd0, pipe_step}, 8'h00);
        check_val("reset_phys_step", {7'd0, phys_step}, 8'h00);
        check_val("reset_jump", {7'd0, jump}, 8'h00);
        check_val("reset_score", Score, 8'h00);
        check_val("reset_hiscore", HiScore, 8'h00);
        check_val("reset_flash", {7'd0, flash}, 8'h00);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge Clk);

        // Start game 1
        press(1'b1);
        push(EV_CLEAR, 8'h00, due);
        push(EV_STATE, 8'h01, due);
        release_after(10);
        check_val("play_state", {6'd0, state}, 8'h01);
        check_val("play_run", {7'd0, run}, 8'h01);
        check_val("play_score", Score, 8'h00);

        // Six frames: pipe every frame, phys on even frames
        for (int i = 1; i <= 6; i++) begin
            start_frame(1'b0, 1'b0);
            push(EV_PIPE, 8'h00, due);
            if (i % 2 == 0) push(EV_PHYS, 8'h00, due);
            idle(3);
        end

        // Four passes, then a collision frame that also carries a pass
        for (int i = 1; i <= 4; i++) begin
            start_pass();
            push(EV_SCORE, to_bcd(i), due);
            idle(2);
        end
        start_frame(1'b1, 1'b1);
        push(EV_STATE, 8'h02, due);
        push(EV_SCORE, 8'h05, due);
        push(EV_HI, 8'h05, due);
        idle(3);

        press(1'b1);
        push(EV_STATE, 8'h00, due);
        release_after(10);
        press(1'b1);
        push(EV_CLEAR, 8'h00, due);
        push(EV_STATE, 8'h01, due);
        push(EV_SCORE, 8'h00, due);
        release_after(10);

        // Game 2: score 07 beats high score 05; no strobes on collision frame
        for (int i = 1; i <= 7; i++) begin
            start_pass();
            push(EV_SCORE, to_bcd(i), due);
            idle(2);
        end
        start_frame(1'b1, 1'b0);
        push(EV_STATE, 8'h02, due);
        push(EV_HI, 8'h07, due);
        idle(3);
        check_val("lose_hiscore", HiScore, 8'h07);
        check_val("lose_run", {7'd0, run}, 8'h00);
        for (int i = 1; i <= 24; i++) begin
            start_frame(1'b0, 1'b0);
            if (i == 12) push(EV_FLASH, 8'h01, due);
            if (i == 24) push(EV_FLASH, 8'h00, due);
            idle(3);
        end

        press(1'b1);
        push(EV_STATE, 8'h00, due);
        release_after(10);
        press(1'b0);
        release_after(10);
        press(1'b1);
        push(EV_CLEAR, 8'h00, due);
        push(EV_STATE, 8'h01, due);
        push(EV_SCORE, 8'h00, due);
        release_after(10);

        // Bounces shorter than the debounce window never produce a jump
        for (int len = 1; len <= 3; len++) begin
            @(negedge Clk);
            BtnC = 1'b1;
            repeat (len) @(negedge Clk);
            BtnC = 1'b0;
            repeat (4) @(negedge Clk);
        end
        press(1'b0);
        push(EV_JUMP, 8'h00, due);
        release_after(10);

        // Game 3: score climbs to 12 then saturates at 99
        for (int i = 1; i <= 112; i++) begin
            start_pass();
            if (i <= 99) push(EV_SCORE, to_bcd(i), due);
            idle(2);
            if (i == 12) check_val("score_12", Score, 8'h12);
        end
        check_val("score_sat", Score, 8'h99);

        // D pulse landing on the collision frame is ignored
        press(1'b1);
        repeat (5) @(negedge Clk);
        start_frame(1'b1, 1'b0);
        push(EV_STATE, 8'h02, due);
        push(EV_HI, 8'h99, due);
        idle(3);
        release_after(7);
        check_val("dpulse_ignored_state", {6'd0, state}, 8'h02);

        press(1'b1);
        push(EV_STATE, 8'h00, due);
        release_after(10);
        press(1'b1);
        push(EV_CLEAR, 8'h00, due);
        push(EV_STATE, 8'h01, due);
        push(EV_SCORE, 8'h00, due);
        release_after(10);
        for (int i = 1; i <= 5; i++) begin
            start_pass();
            push(EV_SCORE, to_bcd(i), due);
            idle(2);
        end

        // Reset mid-game
        @(negedge Clk);
        reset = 1'b1;
        push(EV_STATE, 8'h00, cyc + 1);
        push(EV_SCORE, 8'h00, cyc + 1);
        push(EV_HI, 8'h00, cyc + 1);
        @(negedge Clk);
        reset = 1'b0;
        check_val("rst_state", {6'd0, state}, 8'h00);
        check_val("rst_score", Score, 8'h00);
        check_val("rst_hiscore", HiScore, 8'h00);
        check_val("rst_run", {7'd0, run}, 8'h00);

        repeat (10) @(negedge Clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL missing_events: actual %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
